// File: rtl/serial_word_collector.sv
// Packs qualified serial bits MSB-first into words and queues them in a
// show-ahead FIFO drained over a valid/ready handshake.
module serial_word_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serIn,
  input  logic                   serInValid,
  output logic [WIDTH-1:0]       dataOut,
  output logic                   dataValid,
  input  logic                   dataReady,
  output logic [$clog2(DEPTH):0] fifoCount,
  output logic                   partialDrop,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  shreg_reg, shreg_next;
  logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic              push, drop;
  logic [WIDTH-1:0]  push_word;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg, rd_ptr_plus1;
  logic [AW:0]       count_reg, count_next;
  logic [WIDTH-1:0]  data_out_reg, data_out_next;
  logic              overflow_reg, partial_drop_reg;
  logic              pop, full, wr_en;

  // Truncating cast keeps the low WIDTH bits, so this also covers WIDTH==1.
  assign push_word = WIDTH'({shreg_reg, serIn});

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    push         = 1'b0;
    drop         = 1'b0;
    case (state_reg)
      IDLE: begin
        bit_cnt_next = '0;
        if (serInValid) begin
          shreg_next = push_word;
          if (WIDTH == 1) begin
            push = 1'b1;
          end else begin
            bit_cnt_next = CW'(1);
            state_next   = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (serInValid) begin
          shreg_next = push_word;
          if (bit_cnt_reg == LAST_BIT) begin
            push         = 1'b1;
            bit_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + CW'(1);
          end
        end else begin
          drop         = 1'b1;
          bit_cnt_next = '0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign full         = (count_reg == FULL_CNT);
  assign pop          = dataValid & dataReady;
  assign wr_en        = push & (~full | pop);
  assign rd_ptr_plus1 = rd_ptr_reg + 1'b1;

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop)
      count_next = count_reg + ONE_CNT;
    else if (pop && !wr_en)
      count_next = count_reg - ONE_CNT;
  end

  // The head register is refreshed from storage, or bypassed from the incoming
  // word when that word becomes the new head in the same cycle.
  always_comb begin
    data_out_next = data_out_reg;
    if (pop) begin
      if (count_reg == ONE_CNT) begin
        if (wr_en)
          data_out_next = push_word;
      end else begin
        data_out_next = mem[rd_ptr_plus1];
      end
    end else if (count_reg == '0 && wr_en) begin
      data_out_next = push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      data_out_reg     <= '0;
      overflow_reg     <= 1'b0;
      partial_drop_reg <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_plus1;
      count_reg        <= count_next;
      data_out_reg     <= data_out_next;
      partial_drop_reg <= drop;
      if (push && full && !pop)
        overflow_reg <= 1'b1;
    end
  end

  assign dataOut     = data_out_reg;
  assign dataValid   = (count_reg != '0);
  assign fifoCount   = count_reg;
  assign partialDrop = partial_drop_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed and random checks of serial_word_collector against a queue-based
// model of word assembly and FIFO behaviour.
module tb_serial_word_collector;

  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, serIn, serInValid, dataReady;
  logic [7:0] dataOut;
  logic       dataValid;
  logic [2:0] fifoCount;
  logic       partialDrop, overflow;

  serial_word_collector #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .serIn(serIn), .serInValid(serInValid),
    .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady),
    .fifoCount(fifoCount), .partialDrop(partialDrop), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model state: bits of the word in progress and the queued words.
  bit         m_cur[$];
  logic [7:0] m_fifo[$];
  logic [7:0] m_out;
  logic       m_ovf, m_pd;
  int         m_pd_total;
  int         pd_seen;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic b, input logic rdy);
    logic [7:0] w;
    logic       done;
    logic       pop;
    if (r) begin
      m_cur.delete();
      m_fifo.delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_pd  = 1'b0;
      return;
    end
    pop  = (m_fifo.size() > 0) && rdy;
    done = 1'b0;
    m_pd = 1'b0;
    w    = '0;
    if (v) begin
      m_cur.push_back(b);
      if (m_cur.size() == W) begin
        foreach (m_cur[i]) w = {w[6:0], m_cur[i]};
        done = 1'b1;
        m_cur.delete();
      end
    end else if (m_cur.size() > 0) begin
      m_pd = 1'b1;
      m_pd_total++;
      m_cur.delete();
    end
    if (pop) void'(m_fifo.pop_front());
    if (done) begin
      if (m_fifo.size() < D) m_fifo.push_back(w);
      else m_ovf = 1'b1;
    end
    if (m_fifo.size() > 0) m_out = m_fifo[0];
  endtask

  task automatic cycle(input logic r, input logic v, input logic b, input logic rdy);
    rst = r; serInValid = v; serIn = b; dataReady = rdy;
    model_step(r, v, b, rdy);
    @(posedge clk);
    #1;
    chk("dataValid", dataValid, m_fifo.size() > 0);
    chk("fifoCount", fifoCount, m_fifo.size());
    chk("dataOut", dataOut, m_out);
    chk("partialDrop", partialDrop, m_pd);
    chk("overflow", overflow, m_ovf);
    if (partialDrop) pd_seen++;
  endtask

  task automatic send(input logic [7:0] w, input logic rdy);
    for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, w[i], rdy);
  endtask

  logic [7:0] exp4 [4];
  logic [7:0] word40;

  initial begin
    rst = 1'b1; serIn = 1'b0; serInValid = 1'b0; dataReady = 1'b0;
    m_pd_total = 0; pd_seen = 0;

    // Reset state
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("rst_dataOut", dataOut, 8'h00);
    chk("rst_dataValid", dataValid, 1'b0);
    chk("rst_fifoCount", fifoCount, 3'd0);

    // 1: single word, one cycle latency, popped next edge
    send(8'hA5, 1'b1);
    chk("t1_dataOut", dataOut, 8'hA5);
    chk("t1_dataValid", dataValid, 1'b1);
    cycle(0, 0, 0, 1);
    chk("t1_popped", dataValid, 1'b0);

    // 2: fill with consumer stalled, overflow on fifth word, drain in order
    for (int k = 1; k <= 5; k++) begin
      send(8'(k), 1'b0);
      if (k == 4) chk("t2_full_count", fifoCount, 3'd4);
    end
    chk("t2_overflow", overflow, 1'b1);
    chk("t2_count_after_drop", fifoCount, 3'd4);
    for (int k = 1; k <= 4; k++) begin
      chk("t2_drain_head", dataOut, 32'(k));
      cycle(0, 0, 0, 1);
    end
    chk("t2_drained", dataValid, 1'b0);
    cycle(1, 0, 0, 0);

    // 3: gap inside a word drops it
    repeat (5) cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);
    chk("t3_partialDrop", partialDrop, 1'b1);
    send(8'h3C, 1'b0);
    chk("t3_count", fifoCount, 3'd1);
    chk("t3_dataOut", dataOut, 8'h3C);

    // 4: push and pop together while full, across pointer wrap
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    chk("t4_full", fifoCount, 3'd4);
    word40 = 8'h40;
    for (int i = 7; i >= 1; i--) cycle(0, 1, word40[i], 0);
    cycle(0, 1, word40[0], 1);
    chk("t4_count", fifoCount, 3'd4);
    chk("t4_overflow", overflow, 1'b0);
    exp4[0] = 8'h10; exp4[1] = 8'h20; exp4[2] = 8'h30; exp4[3] = 8'h40;
    for (int k = 0; k < 4; k++) begin
      chk("t4_order", dataOut, exp4[k]);
      cycle(0, 0, 0, 1);
    end

    // 5: reset mid-word with words queued
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    repeat (4) cycle(0, 1, 1, 0);
    cycle(1, 1, 1, 0);
    chk("t5_dataOut", dataOut, 8'h00);
    chk("t5_dataValid", dataValid, 1'b0);
    chk("t5_count", fifoCount, 3'd0);
    chk("t5_partialDrop", partialDrop, 1'b0);
    send(8'hFF, 1'b1);
    chk("t5_ff", dataOut, 8'hFF);
    chk("t5_ff_valid", dataValid, 1'b1);

    // 6: random traffic
    cycle(1, 0, 0, 0);
    pd_seen = 0;
    m_pd_total = 0;
    for (int n = 0; n < 1000; n++)
      cycle(0, $urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 2) != 0);
    chk("t6_partialDrop_total", pd_seen, m_pd_total);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
